// File: rtl/fp_mul_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and helpers for the sequential IEEE-754 multiplier.
//   rnd_mode_e  : rounding-mode encoding as seen on r_mode
//   mul_state_e : controller states
//   fp_flags_t  : exception flags bundled in output order
//   bias()      : exponent bias for a given exponent width
//   qnan()      : canonical quiet NaN pattern (low EXP_W+FRC_W+1 bits used)
// ---------------------------------------------------------------------------
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } mul_state_e;

    typedef struct packed {
        logic ovrf;
        logic udrf;
        logic zer;
        logic inf;
        logic nan;
        logic nx;
    } fp_flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {0, all-ones exponent, 1, zeros}; callers keep the low bits they need.
    function automatic logic [127:0] qnan(input int exp_w, input int frc_w);
        logic [127:0] one;
        one = 128'd1;
        return (((one << exp_w) - one) << frc_w) | (one << (frc_w - 1));
    endfunction

endpackage

// File: rtl/fp_mul_booth_r4.sv
// ---------------------------------------------------------------------------
// fp_mul_booth_r4
// Iterative unsigned radix-4 Booth multiplier, one Booth digit per cycle.
// The multiplier is extended with leading zeros so the top digit is never
// negative, which makes the signed digit set produce an unsigned product.
// All accumulation is done modulo 2^(2W): the true product fits in 2W bits,
// so intermediate negative partial sums wrap harmlessly.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (N iterations follow)
//   a, b       : multiplicand, multiplier (W bits, unsigned)
//   done       : product valid, held until the next start
//   product    : 2W-bit unsigned product
// ---------------------------------------------------------------------------
module fp_mul_booth_r4 #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int N   = (W + 2) / 2;       // ceil((W+1)/2) digits
    localparam int MBW = 2 * N + 1;         // multiplier plus implicit b[-1]
    localparam int CW  = $clog2(N + 1);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [MBW-1:0] mplier_q;
    logic [CW-1:0]  step_q;
    logic           busy_q;
    logic           done_q;
    logic [2*W-1:0] pp;

    // Booth digit from the low three multiplier bits.
    always_comb begin
        // NOTE: default first so every path assigns pp and no latch is inferred.
        pp = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all of them update
    // from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= {{(MBW - W - 1){1'b0}}, b, 1'b0};
            step_q   <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_q + pp;
            mcand_q  <= mcand_q << 2;
            mplier_q <= mplier_q >> 2;
            step_q   <= step_q + 1'b1;
            if (step_q == CW'(N - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_seq
// Multi-cycle IEEE-754 multiplier: radix-4 Booth mantissa product, then one
// cycle of normalise/round. Subnormals flush to signed zero.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only when idle)
//   fp_X, fp_Y, r_mode  : operands and rounding mode, captured on acceptance
//   out_valid/out_ready : result handshake (valid only in DONE)
//   fp_Z                : registered result
//   ovrf..nx            : overflow, underflow, zero, inf, NaN, inexact flags
// ---------------------------------------------------------------------------
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   zer,
    output logic                   inf,
    output logic                   nan,
    output logic                   nx
);

    localparam int W      = EXP_W + FRC_W + 1;
    localparam int MW     = FRC_W + 1;
    localparam int N_ITER = (FRC_W + 3) / 2;
    localparam int CW     = $clog2(N_ITER);
    localparam int EW2    = EXP_W + 2;

    localparam logic [EW2-1:0] BIAS_E    = EW2'(bias(EXP_W));
    localparam logic [EW2-1:0] EMAX_E    = EW2'((1 << EXP_W) - 1);
    localparam logic [127:0]   QNAN_WIDE = qnan(EXP_W, FRC_W);
    localparam logic [W-1:0]   QNAN      = QNAN_WIDE[W-1:0];

    // ---------------- operand decode ----------------
    logic               x_sign, y_sign;
    logic [EXP_W-1:0]   x_exp, y_exp;
    logic [FRC_W-1:0]   x_frc, y_frc;
    logic               x_sub, y_sub, x_inf, y_inf, x_nan, y_nan;
    logic               in_special;
    logic               accept;
    rnd_mode_e          rmode_in;

    assign {x_sign, x_exp, x_frc} = fp_X;
    assign {y_sign, y_exp, y_frc} = fp_Y;

    assign x_sub = (x_exp == '0);
    assign y_sub = (y_exp == '0);
    assign x_inf = (&x_exp) & ~(|x_frc);
    assign y_inf = (&y_exp) & ~(|y_frc);
    assign x_nan = (&x_exp) & (|x_frc);
    assign y_nan = (&y_exp) & (|y_frc);

    assign in_special = x_sub | y_sub | (&x_exp) | (&y_exp);
    assign accept     = in_valid & in_ready;
    // Unused encodings fall back to round-to-nearest-even.
    assign rmode_in   = (r_mode > 3'd4) ? RNE : rnd_mode_e'(r_mode);

    // Special-case result resolved at acceptance, in priority order.
    logic [W-1:0] spec_z_d;
    fp_flags_t    spec_flags_d;

    always_comb begin
        spec_z_d     = '0;
        spec_flags_d = '0;
        if (x_nan | y_nan | (x_inf & y_sub) | (y_inf & x_sub)) begin
            spec_z_d         = QNAN;
            spec_flags_d.nan = 1'b1;
        end else if (x_inf | y_inf) begin
            spec_z_d         = {x_sign ^ y_sign, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            spec_flags_d.inf = 1'b1;
        end else begin
            spec_z_d         = {x_sign ^ y_sign, {(W - 1){1'b0}}};
            spec_flags_d.zer = 1'b1;
        end
    end

    // ---------------- control ----------------
    mul_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q;
    logic [EXP_W-1:0] exp_x_q, exp_y_q;
    rnd_mode_e        rmode_q;
    logic             special_q;
    logic [W-1:0]     spec_z_q;
    fp_flags_t        spec_flags_q;
    logic [W-1:0]     fp_z_q;
    fp_flags_t        flags_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_special ? S_RND : S_MUL;
                    cnt_d   = '0;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N_ITER - 1)) state_d = S_RND;
            end
            S_RND:   state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- mantissa product ----------------
    logic            booth_done;
    logic [2*MW-1:0] booth_prod;

    fp_mul_booth_r4 #(.W(MW)) u_booth (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept & ~in_special),
        .a       ({1'b1, x_frc}),
        .b       ({1'b1, y_frc}),
        .done    (booth_done),
        .product (booth_prod)
    );

    // ---------------- normalise / round ----------------
    logic            norm_n;
    logic [2*MW-1:0] prod_n;
    logic [FRC_W-1:0] frc_kept, frc_rnd;
    logic            grd, rnd, stk, grs, rnd_inc, frc_carry;
    logic [EW2-1:0]  e_z;
    logic            ovf, udf, to_inf;
    logic [W-1:0]    norm_z;
    fp_flags_t       norm_flags;

    assign norm_n   = booth_prod[2*MW-1];
    assign prod_n   = norm_n ? booth_prod : (booth_prod << 1);
    assign frc_kept = prod_n[2*MW-2:MW];
    assign grd      = prod_n[MW-1];
    assign rnd      = prod_n[MW-2];
    assign stk      = |prod_n[MW-3:0];
    assign grs      = grd | rnd | stk;

    always_comb begin
        rnd_inc = 1'b0;
        case (rmode_q)
            RTZ:     rnd_inc = 1'b0;
            RDN:     rnd_inc = sign_q & grs;
            RUP:     rnd_inc = ~sign_q & grs;
            RMM:     rnd_inc = grd;
            default: rnd_inc = grd & (rnd | stk | frc_kept[0]);
        endcase
    end

    // A carry out of the fraction means the mantissa rounded up to 2.0,
    // which is 1.0 with the exponent bumped; the fraction bits are already 0.
    assign {frc_carry, frc_rnd} = {1'b0, frc_kept} + {{FRC_W{1'b0}}, rnd_inc};

    assign e_z = {2'b00, exp_x_q} + {2'b00, exp_y_q} - BIAS_E
               + {{(EW2 - 1){1'b0}}, norm_n} + {{(EW2 - 1){1'b0}}, frc_carry};

    // e_z is two's complement in EW2 bits; the sign bit marks a negative value.
    assign ovf    = ~e_z[EW2-1] & (e_z >= EMAX_E);
    assign udf    = e_z[EW2-1] | (e_z == '0);
    assign to_inf = (rmode_q == RNE) | (rmode_q == RMM)
                  | ((rmode_q == RUP) & ~sign_q) | ((rmode_q == RDN) & sign_q);

    always_comb begin
        norm_z     = {sign_q, e_z[EXP_W-1:0], frc_rnd};
        norm_flags = '0;
        norm_flags.nx = grs;
        if (ovf) begin
            norm_z          = to_inf ? {sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}}
                                     : {sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
            norm_flags.ovrf = 1'b1;
            norm_flags.inf  = to_inf;
            norm_flags.nx   = 1'b1;
        end else if (udf) begin
            norm_z          = {sign_q, {(W - 1){1'b0}}};
            norm_flags.udrf = 1'b1;
            norm_flags.zer  = 1'b1;
            norm_flags.nx   = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            exp_x_q      <= '0;
            exp_y_q      <= '0;
            rmode_q      <= RNE;
            special_q    <= 1'b0;
            spec_z_q     <= '0;
            spec_flags_q <= '0;
            fp_z_q       <= '0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                sign_q       <= x_sign ^ y_sign;
                exp_x_q      <= x_exp;
                exp_y_q      <= y_exp;
                rmode_q      <= rmode_in;
                special_q    <= in_special;
                spec_z_q     <= spec_z_d;
                spec_flags_q <= spec_flags_d;
            end
            // Normal results are only taken once the Booth core reports done.
            if (state_q == S_RND && (special_q || booth_done)) begin
                fp_z_q  <= special_q ? spec_z_q : norm_z;
                flags_q <= special_q ? spec_flags_q : norm_flags;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign fp_Z      = fp_z_q;
    assign {ovrf, udrf, zer, inf, nan, nx} = flags_q;

endmodule
